// File: rtl/bkg_scroll_if.sv
// Control and pixel-path bundle between the VGA timing block, the scroll controller
// and the background pattern mask.
interface bkg_scroll_if #(
  parameter int SCROLL_DIV_W = 4
);
  logic                    vsync;
  logic                    en;
  logic                    pause;
  logic                    clr;
  logic [1:0]              dir;
  logic [SCROLL_DIV_W-1:0] speed;
  logic                    pal_en;
  logic [9:0]              px_in;
  logic [9:0]              py_in;
  logic                    video_on;
  logic [2:0]              col_in;
  logic [9:0]              px_out;
  logic [9:0]              py_out;
  logic [2:0]              rgb_out;
  logic                    busy;

  modport master (
    output vsync, en, pause, clr, dir, speed, pal_en,
    output px_in, py_in, video_on, col_in,
    input  px_out, py_out, rgb_out, busy
  );

  modport slave (
    input  vsync, en, pause, clr, dir, speed, pal_en,
    input  px_in, py_in, video_on, col_in,
    output px_out, py_out, rgb_out, busy
  );
endinterface

// File: rtl/bkg_scroll_ctrl.sv
// Background scroll sequencer: frame-synchronous scroll offsets and palette
// rotation, with a 2-stage pixel path to and from the pattern mask.
module bkg_scroll_ctrl #(
  parameter int SCROLL_DIV_W = 4,
  parameter int PAL_PERIOD   = 32,
  parameter int TILE_LOG2    = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  bkg_scroll_if.slave  bus
);

  localparam int PCW = (PAL_PERIOD > 1) ? $clog2(PAL_PERIOD) : 1;
  localparam logic [PCW-1:0] PAL_LAST = PCW'(PAL_PERIOD - 1);
  localparam logic [TILE_LOG2-1:0] T_ONE = TILE_LOG2'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t state, nxt;

  logic                    vsync_q;
  logic                    tick;
  logic                    adv;
  logic [SCROLL_DIV_W-1:0] frame_cnt;
  logic [PCW-1:0]          pal_cnt;
  logic [1:0]              pal_step;
  logic [TILE_LOG2-1:0]    x_off;
  logic [TILE_LOG2-1:0]    y_off;
  logic                    von_d;
  logic [2:0]              rot;

  assign tick = vsync_q & ~bus.vsync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= nxt;
    end
  end

  // en=0 takes priority over pause from every state
  always_comb begin
    nxt = state;
    case (state)
      IDLE: if (bus.en) nxt = RUN;
      RUN: begin
        if (!bus.en)        nxt = IDLE;
        else if (bus.pause) nxt = HOLD;
      end
      HOLD: begin
        if (!bus.en)         nxt = IDLE;
        else if (!bus.pause) nxt = RUN;
      end
      default: nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.busy = (state == RUN);
    adv      = (state == RUN) & tick & ~bus.clr;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_q <= 1'b1;
    end else begin
      vsync_q <= bus.vsync;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt <= '0;
      pal_cnt   <= '0;
      pal_step  <= 2'd0;
      x_off     <= '0;
      y_off     <= '0;
    end else if (bus.clr) begin
      frame_cnt <= '0;
      pal_cnt   <= '0;
      pal_step  <= 2'd0;
      x_off     <= '0;
      y_off     <= '0;
    end else if (adv) begin
      if (frame_cnt == bus.speed) begin
        frame_cnt <= '0;
        case (bus.dir)
          2'b00:   x_off <= x_off - T_ONE;
          2'b01:   x_off <= x_off + T_ONE;
          2'b10:   y_off <= y_off - T_ONE;
          default: y_off <= y_off + T_ONE;
        endcase
      end else begin
        frame_cnt <= frame_cnt + 1'b1;
      end
      if (bus.pal_en) begin
        if (pal_cnt == PAL_LAST) begin
          pal_cnt  <= '0;
          pal_step <= (pal_step == 2'd2) ? 2'd0 : pal_step + 2'd1;
        end else begin
          pal_cnt <= pal_cnt + 1'b1;
        end
      end
    end
  end

  always_comb begin
    rot = bus.col_in;
    unique case (1'b1)
      (pal_step == 2'd1): rot = {bus.col_in[1:0], bus.col_in[2]};
      (pal_step == 2'd2): rot = {bus.col_in[0], bus.col_in[2:1]};
      default:            rot = bus.col_in;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.px_out  <= '0;
      bus.py_out  <= '0;
      von_d       <= 1'b0;
      bus.rgb_out <= 3'b000;
    end else begin
      bus.px_out  <= bus.px_in + 10'(x_off);
      bus.py_out  <= bus.py_in + 10'(y_off);
      von_d       <= bus.video_on;
      bus.rgb_out <= von_d ? rot : 3'b000;
    end
  end

endmodule

// File: tb/tb_bkg_scroll_ctrl.sv
// Directed + randomized bench for bkg_scroll_ctrl against a frame-level
// model of offsets, divider and palette rotation.
module tb_bkg_scroll_ctrl;

  localparam int SDW = 4;
  localparam int PALP = 2;
  localparam int TILE = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b1;

  bkg_scroll_if #(.SCROLL_DIV_W(SDW)) bus ();

  bkg_scroll_ctrl #(
    .SCROLL_DIV_W(SDW),
    .PAL_PERIOD  (PALP),
    .TILE_LOG2   (4)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int nerr = 0;
  int nchk = 0;

  // frame-level model
  int xo, yo, fc, pc, ps;
  bit running;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic void m_reset();
    xo = 0; yo = 0; fc = 0; pc = 0; ps = 0;
  endfunction

  function automatic void m_tick();
    if (!running) return;
    if (fc == int'(bus.speed)) begin
      fc = 0;
      case (bus.dir)
        2'b00: xo = (xo + TILE - 1) % TILE;
        2'b01: xo = (xo + 1) % TILE;
        2'b10: yo = (yo + TILE - 1) % TILE;
        default: yo = (yo + 1) % TILE;
      endcase
    end else begin
      fc = fc + 1;
    end
    if (bus.pal_en) begin
      pc = pc + 1;
      if (pc == PALP) begin
        pc = 0;
        ps = (ps + 1) % 3;
      end
    end
  endfunction

  function automatic int m_rot(input int c, input int s);
    return ((c << s) | (c >> (3 - s))) & 7;
  endfunction

  task automatic setmode(input bit e, input bit p);
    bus.en = e; bus.pause = p;
    cyc(2);
    running = e && !p;
  endtask

  task automatic frame(input bit with_clr);
    bus.vsync = 1'b0;
    bus.clr = with_clr;
    cyc(1);
    bus.clr = 1'b0;
    if (with_clr) m_reset();
    else m_tick();
    cyc(2);
    bus.vsync = 1'b1;
    cyc(3);
  endtask

  task automatic pulse_clr();
    bus.clr = 1'b1;
    cyc(1);
    bus.clr = 1'b0;
    m_reset();
  endtask

  task automatic probe(input string tag, input int px, input int py);
    bit v;
    int c;
    v = 1'($urandom_range(0, 1));
    c = int'($urandom_range(0, 7));
    bus.px_in = 10'(px);
    bus.py_in = 10'(py);
    bus.video_on = v;
    bus.col_in = 3'(c);
    cyc(1);
    chk({tag, "_px"}, 32'(bus.px_out), 32'((px + xo) % 1024));
    chk({tag, "_py"}, 32'(bus.py_out), 32'((py + yo) % 1024));
    cyc(1);
    chk({tag, "_rgb"}, 32'(bus.rgb_out), v ? 32'(m_rot(c, ps)) : 32'd0);
    chk({tag, "_busy"}, 32'(bus.busy), 32'(running));
  endtask

  task automatic rnd_probe(input string tag);
    probe(tag, int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)));
  endtask

  initial begin
    bus.vsync = 1'b1; bus.en = 1'b0; bus.pause = 1'b0; bus.clr = 1'b0;
    bus.dir = 2'b00; bus.speed = '0; bus.pal_en = 1'b0;
    bus.px_in = '0; bus.py_in = '0; bus.video_on = 1'b0; bus.col_in = '0;
    running = 1'b0;
    m_reset();

    #3 rst_n = 1'b0;
    cyc(3);
    chk("rst_px", 32'(bus.px_out), 0);
    chk("rst_py", 32'(bus.py_out), 0);
    chk("rst_rgb", 32'(bus.rgb_out), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    rst_n = 1'b1;
    cyc(2);
    probe("idle", 37, 500);

    // left scroll every frame, wraps past 15
    bus.dir = 2'b01; bus.speed = 4'd0;
    setmode(1, 0);
    repeat (17) frame(0);
    probe("left17", 100, 0);

    // down scroll every third frame
    bus.dir = 2'b10; bus.speed = 4'd2;
    for (int i = 1; i <= 6; i++) begin
      frame(0);
      probe($sformatf("down%0d", i), 200, 10);
    end

    // pause freezes everything
    bus.dir = 2'b00; bus.speed = 4'd1;
    setmode(1, 1);
    repeat (4) frame(0);
    probe("paused", 5, 6);
    setmode(1, 0);
    repeat (3) frame(0);
    probe("resumed", 5, 6);

    // clr coincident with a tick
    pulse_clr();
    bus.dir = 2'b01; bus.speed = 4'd0;
    repeat (7) frame(0);
    probe("x7", 0, 0);
    frame(1);
    probe("clr_tick", 0, 0);
    frame(0);
    probe("after_clr", 0, 0);

    // palette rotation, period 2
    pulse_clr();
    bus.speed = 4'd15;
    bus.pal_en = 1'b1;
    bus.col_in = 3'b100;
    bus.video_on = 1'b1;
    cyc(2);
    chk("pal0", 32'(bus.rgb_out), 32'b100);
    for (int k = 1; k <= 3; k++) begin
      repeat (2) frame(0);
      chk($sformatf("pal%0d", k), 32'(bus.rgb_out), 32'(m_rot(4, ps)));
    end
    bus.video_on = 1'b0;
    cyc(1);
    chk("von_lat1", 32'(bus.rgb_out), 32'b100);
    cyc(1);
    chk("von_off", 32'(bus.rgb_out), 0);

    // randomized traffic
    for (int i = 0; i < 40; i++) begin
      bus.dir = 2'($urandom_range(0, 3));
      bus.speed = SDW'($urandom_range(0, 3));
      bus.pal_en = 1'($urandom_range(0, 1));
      setmode(($urandom_range(0, 5) != 0), ($urandom_range(0, 4) == 0));
      if ($urandom_range(0, 9) == 0) pulse_clr();
      repeat ($urandom_range(1, 4)) frame($urandom_range(0, 15) == 0);
      rnd_probe($sformatf("rnd%0d", i));
    end

    // async reset mid-run with a nonzero offset
    bus.dir = 2'b01; bus.speed = 4'd0;
    setmode(1, 0);
    repeat (5) frame(0);
    bus.video_on = 1'b1;
    bus.px_in = 10'd300;
    cyc(2);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_px", 32'(bus.px_out), 0);
    chk("arst_py", 32'(bus.py_out), 0);
    chk("arst_rgb", 32'(bus.rgb_out), 0);
    chk("arst_busy", 32'(bus.busy), 0);
    cyc(2);
    @(posedge clk);
    #1 rst_n = 1'b1;
    m_reset();
    running = 1'b0;
    cyc(2);
    running = 1'b1;
    probe("post_rst", 300, 40);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule
